reg_bank_rw: RTL and testbench

- General-purpose register bank for the multicycle MIPS datapath: 32 x DATA_W registers, one write port, two read ports, registered A/B operand latches.
- Sits downstream of the write-register select mux. Consumes its 5-bit destination index with RegWrite and WriteData, and serves rs/rt reads to the ALU operand path.
- Provides a registered sticky flag when a never-written register is read, for bench and debug use.

---
 rtl/reg_bank_rw.sv | 107 ++++++++++
 tb/tb_reg_bank_rw.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_rw.sv
// 32-entry general-purpose register bank with one write port, two bypassed read ports,
// registered A/B operand latches and a sticky flag for reads of never-written registers.
module reg_bank_rw #(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(227),
  parameter logic [DATA_W-1:0]  RA_RESET = DATA_W'(0)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  input  logic              LoadAB,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] A_out,
  output logic [DATA_W-1:0] B_out,
  output logic              UninitRead
);

  // Registers 0, 29 and 31 hold defined values out of reset, so they count as written.
  localparam logic [31:0] MASK_RESET = 32'hA000_0001;

  logic [DATA_W-1:0] regs_r [32];
  logic [31:0]       written_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              uninit_r;

  logic              write_en_s;
  logic              bypass1_s;
  logic              bypass2_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic              uninit1_s;
  logic              uninit2_s;

  function automatic logic [DATA_W-1:0] reset_value(input logic [4:0] idx);
    case (idx)
      5'd29:   reset_value = SP_RESET;
      5'd31:   reset_value = RA_RESET;
      default: reset_value = '0;
    endcase
  endfunction

  // Read ports: register 0 is hard-wired, then write-first bypass, then storage.
  always_comb begin
    write_en_s = RegWrite && (WriteReg != 5'd0);
    bypass1_s  = write_en_s && (WriteReg == ReadReg1);
    bypass2_s  = write_en_s && (WriteReg == ReadReg2);
    rd1_s      = '0;
    rd2_s      = '0;
    if (ReadReg1 == 5'd0) begin
      rd1_s = '0;
    end else if (bypass1_s) begin
      rd1_s = WriteData;
    end else begin
      rd1_s = regs_r[ReadReg1];
    end
    if (ReadReg2 == 5'd0) begin
      rd2_s = '0;
    end else if (bypass2_s) begin
      rd2_s = WriteData;
    end else begin
      rd2_s = regs_r[ReadReg2];
    end
    uninit1_s = !written_r[ReadReg1] && !bypass1_s;
    uninit2_s = !written_r[ReadReg2] && !bypass2_s;
  end

  // Storage and written-mask update; reset wins over any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= reset_value(5'(i));
      end
      written_r <= MASK_RESET;
    end else if (write_en_s) begin
      regs_r[WriteReg]    <= WriteData;
      written_r[WriteReg] <= 1'b1;
    end
  end

  // Operand latches and sticky uninitialised-read flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= '0;
      b_r      <= '0;
      uninit_r <= 1'b0;
    end else if (LoadAB) begin
      a_r <= rd1_s;
      b_r <= rd2_s;
      if (uninit1_s || uninit2_s) begin
        uninit_r <= 1'b1;
      end
    end
  end

  assign ReadData1  = rd1_s;
  assign ReadData2  = rd2_s;
  assign A_out      = a_r;
  assign B_out      = b_r;
  assign UninitRead = uninit_r;

endmodule

// File: tb/tb_reg_bank_rw.sv
// Scoreboard bench for reg_bank_rw: a reference model pushes expected values per
// stimulus cycle and DUT outputs are popped and compared after they settle.
module tb_reg_bank_rw;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        LoadAB;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] A_out;
  logic [31:0] B_out;
  logic        UninitRead;

  logic        s_reset;
  logic        s_we;
  logic [4:0]  s_wr;
  logic [15:0] s_wd;
  logic [4:0]  s_r1;
  logic [4:0]  s_r2;
  logic        s_ld;
  logic [15:0] s_rd1;
  logic [15:0] s_rd2;
  logic [15:0] s_a;
  logic [15:0] s_b;
  logic        s_uninit;

  reg_bank_rw dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .LoadAB(LoadAB),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .A_out(A_out), .B_out(B_out),
    .UninitRead(UninitRead)
  );

  reg_bank_rw #(.DATA_W(16), .SP_RESET(16'd1000), .RA_RESET(16'd0)) dut16 (
    .clk(clk), .reset(s_reset), .RegWrite(s_we), .WriteReg(s_wr),
    .WriteData(s_wd), .ReadReg1(s_r1), .ReadReg2(s_r2), .LoadAB(s_ld),
    .ReadData1(s_rd1), .ReadData2(s_rd2), .A_out(s_a), .B_out(s_b),
    .UninitRead(s_uninit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_mask;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_uninit;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_reg[29] = 32'd227;
    m_reg[31] = 32'd0;
    m_mask    = 32'd0;
    m_mask[0] = 1'b1;
    m_mask[29] = 1'b1;
    m_mask[31] = 1'b1;
    m_a      = 32'd0;
    m_b      = 32'd0;
    m_uninit = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wr == idx) return wd;
    return m_reg[idx];
  endfunction

  // One clock of stimulus: checks combinational reads before the edge, registered state after.
  task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic ld);
    logic [31:0] e1;
    logic [31:0] e2;
    logic        byp1;
    logic        byp2;
    @(negedge clk);
    reset = rst; RegWrite = we; WriteReg = wr; WriteData = wd;
    ReadReg1 = r1; ReadReg2 = r2; LoadAB = ld;
    e1   = model_read(r1, we, wr, wd);
    e2   = model_read(r2, we, wr, wd);
    byp1 = we && (wr != 5'd0) && (wr == r1);
    byp2 = we && (wr != 5'd0) && (wr == r2);
    sb_push("rd1", e1);
    sb_push("rd2", e2);
    if (rst) begin
      model_reset();
    end else begin
      if (ld) begin
        if ((!m_mask[r1] && !byp1) || (!m_mask[r2] && !byp2)) m_uninit = 1'b1;
        m_a = e1;
        m_b = e2;
      end
      if (we && wr != 5'd0) begin
        m_reg[wr]  = wd;
        m_mask[wr] = 1'b1;
      end
    end
    #1;
    sb_check(ReadData1);
    sb_check(ReadData2);
    sb_push("a_out", m_a);
    sb_push("b_out", m_b);
    sb_push("uninit", {31'd0, m_uninit});
    @(posedge clk);
    #1;
    sb_check(A_out);
    sb_check(B_out);
    sb_check({31'd0, UninitRead});
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'd0;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0; LoadAB = 1'b0;
    s_reset = 1'b1; s_we = 1'b0; s_wr = 5'd0; s_wd = 16'd0;
    s_r1 = 5'd0; s_r2 = 5'd0; s_ld = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    sb_push("rst_a", 32'd0);
    sb_push("rst_b", 32'd0);
    sb_push("rst_uninit", 32'd0);
    sb_check(A_out);
    sb_check(B_out);
    sb_check({31'd0, UninitRead});

    // Reset values and uninitialised read of reg5
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd5, 1'b1);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    // Write and read back, register 0 ignored
    drive(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 1'b0);
    drive(1'b0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 1'b0);
    // Same-cycle write, bypass and latch
    drive(1'b0, 1'b1, 5'd9, 32'h55, 5'd9, 5'd9, 1'b1);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd8, 1'b1);
    // Reset beats write and latch; bypass still visible during reset
    drive(1'b1, 1'b1, 5'd31, 32'hFFFF0000, 5'd31, 5'd9, 1'b1);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd9, 1'b1);
    // Back-to-back writes, SP restored by reset
    drive(1'b0, 1'b1, 5'd31, 32'h100, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 1'b1, 5'd31, 32'h200, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 1'b1, 5'd29, 32'h10, 5'd31, 5'd0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd31, 1'b1);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd31, 1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom(), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
    end

    // Narrow instance with overridden stack-pointer reset
    @(negedge clk);
    s_reset = 1'b0; s_r1 = 5'd29;
    sb_push("w16_sp", 32'd1000);
    #1;
    sb_check({16'd0, s_rd1});
    @(negedge clk);
    s_we = 1'b1; s_wr = 5'd3; s_wd = 16'hABCD;
    @(negedge clk);
    s_we = 1'b0; s_r2 = 5'd3;
    sb_push("w16_r3", 32'h0000ABCD);
    #1;
    sb_check({16'd0, s_rd2});

    if (sb_q.size() != 0) check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
